// File: rtl/spi_sram_bist.sv
// Self-test engine for the spi_sram controller: fills bursts with a pattern, reads them back and checks.
// Define SRAM_BIST_LFSR_EN to enable the LFSR pattern (pattern_sel=2); otherwise mode 2 falls back to AA/55.
module spi_sram_bist #(
    parameter int          ADDR_WIDTH = 16,
    parameter int          BURST_LEN  = 16,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            pattern_sel,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [15:0]           num_bursts,
    output logic                  busy,
    output logic                  pass,
    output logic                  fail,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [7:0]            fail_exp,
    output logic [7:0]            fail_got,
    input  logic                  sram_done,
    output logic [7:0]            sram_data_in,
    output logic                  sram_data_in_valid,
    input  logic [7:0]            sram_data_out,
    output logic                  sram_data_out_read,
    input  logic                  sram_data_out_empty,
    output logic                  sram_write_cmd,
    output logic                  sram_read_cmd,
    output logic [5:0]            sram_read_cmd_size,
    output logic [23:0]           sram_address
);
    // state    | meaning
    // IDLE     | waiting for start
    // WAIT_RDY | waiting for controller idle
    // FILL     | pushing one burst of pattern bytes
    // WR_CMD   | write command pulse
    // WR_WAIT  | waiting for write to finish (done low then high)
    // RD_CMD   | read command pulse
    // RD_WAIT  | waiting for read to finish (done low then high)
    // CHECK    | popping and comparing one burst
    // DONE     | publishing result
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_RDY, S_FILL, S_WR_CMD, S_WR_WAIT,
        S_RD_CMD, S_RD_WAIT, S_CHECK, S_DONE
    } state_t;

    localparam logic [5:0]            BL6    = 6'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] BL_AW  = ADDR_WIDTH'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] ONE_AW = ADDR_WIDTH'(1);

    state_t                state, state_nx;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q, burst_addr, byte_addr;
    logic [15:0]           num_bursts_q, burst_left;
    logic [5:0]            byte_left, size_q;
    logic                  seen_low;
    logic [7:0]            pat;
    logic [23:0]           byte_addr24;

    wire byte_last = (byte_left == 6'd1);
    wire burst_last = (burst_left == 16'd1);
    wire wait_done = seen_low & sram_done;

    assign byte_addr24        = 24'(byte_addr);
    assign sram_address       = 24'(burst_addr);
    assign sram_read_cmd_size = size_q;

`ifdef SRAM_BIST_LFSR_EN
    logic [7:0] lfsr;

    // Restarted from the seed for each phase so the read side regenerates the written stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= 8'h00;
        else if ((state == S_IDLE && start) || (state == S_WR_WAIT && wait_done && burst_last))
            lfsr <= LFSR_SEED;
        else if (state == S_FILL || (state == S_CHECK && !sram_data_out_empty))
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`endif

    always_comb begin
        pat = byte_addr24[0] ? 8'h55 : 8'hAA;
        case (mode_q)
            2'd1:    pat = byte_addr24[7:0];
            2'd3:    pat = ~byte_addr24[7:0];
`ifdef SRAM_BIST_LFSR_EN
            2'd2:    pat = lfsr;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nx           = state;
        sram_data_in       = 8'h00;
        sram_data_in_valid = 1'b0;
        sram_data_out_read = 1'b0;
        sram_write_cmd     = 1'b0;
        sram_read_cmd      = 1'b0;
        case (state)
            S_IDLE:     if (start) state_nx = (num_bursts == 16'd0) ? S_DONE : S_WAIT_RDY;
            S_WAIT_RDY: if (sram_done) state_nx = S_FILL;
            S_FILL: begin
                sram_data_in       = pat;
                sram_data_in_valid = 1'b1;
                if (byte_last) state_nx = S_WR_CMD;
            end
            S_WR_CMD: begin
                sram_write_cmd = 1'b1;
                state_nx       = S_WR_WAIT;
            end
            S_WR_WAIT:  if (wait_done) state_nx = burst_last ? S_RD_CMD : S_FILL;
            S_RD_CMD: begin
                sram_read_cmd = 1'b1;
                state_nx      = S_RD_WAIT;
            end
            S_RD_WAIT:  if (wait_done) state_nx = S_CHECK;
            S_CHECK: begin
                if (!sram_data_out_empty) begin
                    sram_data_out_read = 1'b1;
                    if (byte_last) state_nx = burst_last ? S_DONE : S_RD_CMD;
                end
            end
            S_DONE:     state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            err_count    <= 16'd0;
            fail_addr    <= '0;
            fail_exp     <= 8'h00;
            fail_got     <= 8'h00;
            mode_q       <= 2'd0;
            base_q       <= '0;
            burst_addr   <= '0;
            byte_addr    <= '0;
            num_bursts_q <= 16'd0;
            burst_left   <= 16'd0;
            byte_left    <= 6'd0;
            size_q       <= 6'd0;
            seen_low     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (start) begin
                    busy         <= 1'b1;
                    pass         <= 1'b0;
                    fail         <= 1'b0;
                    err_count    <= 16'd0;
                    fail_addr    <= '0;
                    fail_exp     <= 8'h00;
                    fail_got     <= 8'h00;
                    mode_q       <= pattern_sel;
                    base_q       <= base_addr;
                    burst_addr   <= base_addr;
                    byte_addr    <= base_addr;
                    num_bursts_q <= num_bursts;
                    burst_left   <= num_bursts;
                    byte_left    <= BL6;
                    size_q       <= BL6;
                end
                S_FILL: begin
                    byte_addr <= byte_addr + ONE_AW;
                    byte_left <= byte_last ? BL6 : byte_left - 6'd1;
                end
                S_WR_CMD, S_RD_CMD: seen_low <= 1'b0;
                S_WR_WAIT: begin
                    seen_low <= seen_low | ~sram_done;
                    if (wait_done) begin
                        if (burst_last) begin
                            // write phase over: rewind for the read phase
                            burst_left <= num_bursts_q;
                            burst_addr <= base_q;
                            byte_addr  <= base_q;
                        end else begin
                            burst_left <= burst_left - 16'd1;
                            burst_addr <= burst_addr + BL_AW;
                        end
                    end
                end
                S_RD_WAIT: seen_low <= seen_low | ~sram_done;
                S_CHECK: if (!sram_data_out_empty) begin
                    if (sram_data_out != pat) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == 16'd0) begin
                            fail_addr <= byte_addr;
                            fail_exp  <= pat;
                            fail_got  <= sram_data_out;
                        end
                    end
                    byte_addr <= byte_addr + ONE_AW;
                    byte_left <= byte_last ? BL6 : byte_left - 6'd1;
                    if (byte_last) begin
                        burst_left <= burst_left - 16'd1;
                        burst_addr <= burst_addr + BL_AW;
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    pass <= (err_count == 16'd0);
                    fail <= (err_count != 16'd0);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_bist.sv
// Bench for spi_sram_bist: behavioural FIFO/command SRAM controller model plus a
// byte-stream reference computed directly from the pattern rules.
module tb_spi_sram_bist;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] base_addr = 16'h0;
    logic [15:0] num_bursts = 16'h0;
    logic        busy, pass, fail;
    logic [15:0] err_count, fail_addr;
    logic [7:0]  fail_exp, fail_got;
    logic        sram_done = 1'b1;
    logic [7:0]  sram_data_in;
    logic        sram_data_in_valid;
    logic [7:0]  sram_data_out = 8'h00;
    logic        sram_data_out_read;
    logic        sram_data_out_empty = 1'b1;
    logic        sram_write_cmd, sram_read_cmd;
    logic [5:0]  sram_read_cmd_size;
    logic [23:0] sram_address;

    spi_sram_bist #(.ADDR_WIDTH(16), .BURST_LEN(BL), .LFSR_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_sel(pattern_sel),
        .base_addr(base_addr), .num_bursts(num_bursts), .busy(busy), .pass(pass),
        .fail(fail), .err_count(err_count), .fail_addr(fail_addr), .fail_exp(fail_exp),
        .fail_got(fail_got), .sram_done(sram_done), .sram_data_in(sram_data_in),
        .sram_data_in_valid(sram_data_in_valid), .sram_data_out(sram_data_out),
        .sram_data_out_read(sram_data_out_read), .sram_data_out_empty(sram_data_out_empty),
        .sram_write_cmd(sram_write_cmd), .sram_read_cmd(sram_read_cmd),
        .sram_read_cmd_size(sram_read_cmd_size), .sram_address(sram_address)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- SRAM controller model ----------------
    logic [7:0]  mem [0:65535];
    logic [7:0]  wq[$];
    logic [7:0]  rq[$];
    logic [24:0] cmd_log[$];
    int          lat = 0;
    bit          op_rd = 1'b0;
    logic [23:0] op_addr = 24'h0;
    int          n_push = 0, n_cmd = 0, n_rd = 0, n_bad_pop = 0, n_bad_size = 0;
    bit          flt_en = 1'b0;
    logic [15:0] flt_addr = 16'h0;
    logic [7:0]  flt_mask = 8'h0;

    always @(posedge clk) begin
        if (!rst_n) begin
            wq.delete();
            rq.delete();
            lat = 0;
            sram_done <= 1'b1;
        end else begin
            if (sram_data_in_valid) begin
                wq.push_back(sram_data_in);
                n_push++;
            end
            if (sram_data_out_read) begin
                if (rq.size() == 0) n_bad_pop++;
                else void'(rq.pop_front());
            end
            if (sram_write_cmd || sram_read_cmd) begin
                n_cmd++;
                if (sram_read_cmd) begin
                    n_rd++;
                    if (sram_read_cmd_size != 6'(BL)) n_bad_size++;
                end
                cmd_log.push_back({sram_read_cmd, sram_address});
                op_rd   = sram_read_cmd;
                op_addr = sram_address;
                lat     = 2 + $urandom_range(0, 3);
                sram_done <= 1'b0;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    for (int i = 0; i < BL; i++) begin
                        logic [15:0] a;
                        a = op_addr[15:0] + 16'(i);
                        if (!op_rd) begin
                            if (wq.size() > 0) mem[a] = wq.pop_front();
                        end else begin
                            rq.push_back(mem[a] | ((flt_en && a == flt_addr) ? flt_mask : 8'h00));
                        end
                    end
                    sram_done <= 1'b1;
                end
            end
        end
        sram_data_out       <= (rq.size() > 0) ? rq[0] : 8'h00;
        sram_data_out_empty <= (rq.size() == 0);
    end

    // ---------------- reference pattern ----------------
    function automatic logic [7:0] lfsr_nth(input int n);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s;
    endfunction

    function automatic logic [7:0] pat(input int mode, input logic [15:0] a, input int idx);
        logic [7:0] alt;
        alt = a[0] ? 8'h55 : 8'hAA;
        case (mode)
            1: return a[7:0];
            3: return ~a[7:0];
`ifdef SRAM_BIST_LFSR_EN
            2: return lfsr_nth(idx);
`endif
            default: return alt;
        endcase
    endfunction

    task automatic run_test(input logic [15:0] base, input int nb, input int mode, input bit dbl);
        int          n, exp_err, bad, cyc;
        logic [15:0] e_addr, a;
        logic [7:0]  e_exp, e_got, e, g;
        n = nb * BL;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            mem[a] = ~pat(mode, a, i);
        end
        cmd_log.delete();
        n_push = 0;
        n_cmd  = 0;
        @(negedge clk);
        base_addr   = base;
        num_bursts  = 16'(nb);
        pattern_sel = 2'(mode);
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_on", busy, 1);
        check("res_clr", {pass, fail, err_count}, 0);
        if (dbl) begin
            repeat (3) @(negedge clk);
            base_addr   = ~base;
            num_bursts  = 16'd1;
            pattern_sel = 2'(mode ^ 1);
            start       = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (cyc = 0; busy && cyc < 5000; cyc++) @(negedge clk);
        check("timeout", busy, 0);

        exp_err = 0;
        e_addr = 16'h0; e_exp = 8'h0; e_got = 8'h0;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            e = pat(mode, a, i);
            g = e | ((flt_en && a == flt_addr) ? flt_mask : 8'h00);
            if (g != e) begin
                if (exp_err == 0) begin
                    e_addr = a; e_exp = e; e_got = g;
                end
                exp_err++;
            end
        end
        check("pass", pass, (exp_err == 0));
        check("fail", fail, (exp_err != 0));
        check("err_count", err_count, 32'(exp_err));
        check("fail_addr", fail_addr, e_addr);
        check("fail_exp", fail_exp, e_exp);
        check("fail_got", fail_got, e_got);
        check("n_cmd", n_cmd, 2 * nb);
        check("n_push", n_push, n);
        for (int k = 0; k < cmd_log.size() && k < 2 * nb; k++)
            check("cmd", cmd_log[k], {(k >= nb), 8'h00, 16'(base + 16'((k % nb) * BL))});
        bad = 0;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            if (mem[a] !== pat(mode, a, i)) bad++;
        end
        check("wr_data", bad, 0);
        check("rq_drained", rq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ctl", {busy, pass, fail, sram_data_in_valid, sram_data_out_read,
                          sram_write_cmd, sram_read_cmd}, 0);
        check("rst_val", {err_count, fail_exp, fail_got}, 0);
        check("rst_addr", {sram_address, sram_read_cmd_size, sram_data_in}, 0);
        rst_n = 1'b1;

        // pattern 0 basic, then address wrap, then stuck bit
        run_test(16'h1122, 1, 0, 1'b0);
        run_test(16'hFFF0, 2, 1, 1'b0);
        flt_en = 1'b1; flt_addr = 16'h0005; flt_mask = 8'h08;
        run_test(16'h0000, 1, 1, 1'b0);
        check("t3_addr", fail_addr, 16'h0005);
        check("t3_got", {fail_exp, fail_got}, 16'h050D);
        flt_en = 1'b0;

        // null test
        n_push = 0; n_cmd = 0;
        @(negedge clk);
        num_bursts = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("null_res", {busy, pass, fail}, 3'b010);
        repeat (5) @(negedge clk);
        check("null_traffic", n_push + n_cmd, 0);

        // reset during read wait
        n_rd = 0;
        @(negedge clk);
        base_addr = 16'h0300; num_bursts = 16'd1; pattern_sel = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; n_rd == 0 && c < 500; c++) @(negedge clk);
        check("rd_seen", n_rd, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ctl", {busy, pass, fail, sram_data_out_read, sram_read_cmd}, 0);
        check("abort_val", {err_count, sram_read_cmd_size}, 0);
        check("abort_addr", sram_address, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_test(16'h0300, 1, 0, 1'b0);

        // LFSR (or fallback) with ignored second start
        run_test(16'h4000, 4, 2, 1'b1);

        for (int t = 0; t < 6; t++) begin
            logic [15:0] b;
            int          nb, md;
            b  = 16'($urandom);
            nb = $urandom_range(1, 3);
            md = $urandom_range(0, 3);
            flt_en   = ($urandom_range(0, 1) == 1);
            flt_addr = b + 16'($urandom_range(0, nb * BL - 1));
            flt_mask = 8'(1 << $urandom_range(0, 7));
            run_test(b, nb, md, ($urandom_range(0, 1) == 1));
            flt_en = 1'b0;
        end

        check("pop_empty", n_bad_pop, 0);
        check("rd_size", n_bad_size, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
